// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port RAM between instruction fetch and data access.
// Data requests take priority; a watchdog flags a hung RAM through the sticky bus_err.
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    input  logic        if_flush,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic        ram_en,
    output logic        ram_we,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,
    input  logic        ram_ready,
    output logic [15:0] if_data,
    output logic        if_valid,
    output logic [15:0] mem_rdata,
    output logic        mem_done,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

    state_t     state, stateNext;
    logic       discard;
    logic [7:0] toCnt;
    logic       dataReq, fetchReq, busy, timeoutHit;
    logic       grantData, grantFetch;

    // A requester whose pulse is showing still holds its request for that cycle; mask it.
    assign dataReq    = (mem_rd | mem_wr) & ~mem_done;
    assign fetchReq   = if_req & ~if_valid;
    assign busy       = (state != IDLE);
    assign timeoutHit = busy & ~ram_ready & (({1'b0, toCnt} + 9'd1) >= 9'(TIMEOUT));

    assign ram_en    = busy;
    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = (mem_rd | mem_wr) & ~mem_done;

    always_comb begin
        stateNext  = state;
        grantData  = 1'b0;
        grantFetch = 1'b0;
        case (state)
            IDLE: begin
                if (dataReq)       grantData  = 1'b1;
                else if (fetchReq) grantFetch = 1'b1;
            end
            FETCH: if (ram_ready && dataReq)  grantData  = 1'b1;
            DATA:  if (ram_ready && fetchReq) grantFetch = 1'b1;
            default: ;
        endcase
        if (grantData)                         stateNext = DATA;
        else if (grantFetch)                   stateNext = FETCH;
        else if ((busy && ram_ready) || timeoutHit) stateNext = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            if_data   <= '0;
            mem_rdata <= '0;
            if_valid  <= 1'b0;
            mem_done  <= 1'b0;
            discard   <= 1'b0;
            toCnt     <= '0;
            bus_err   <= 1'b0;
        end else begin
            state    <= stateNext;
            if_valid <= 1'b0;
            mem_done <= 1'b0;

            if (grantData || grantFetch)
                toCnt <= '0;
            else if (busy && !ram_ready && toCnt != 8'hFF)
                toCnt <= toCnt + 8'd1;

            if (grantData) begin
                ram_addr  <= mem_addr;
                ram_we    <= mem_wr;
                ram_wdata <= mem_wdata;
            end else if (grantFetch) begin
                ram_addr  <= if_addr;
                ram_we    <= 1'b0;
                ram_wdata <= '0;
            end else if (stateNext == IDLE) begin
                ram_we <= 1'b0;
            end

            if (timeoutHit)
                bus_err <= 1'b1;

            if (state == DATA && ram_ready) begin
                mem_done <= 1'b1;
                if (!ram_we)
                    mem_rdata <= ram_rdata;
            end

            // The fetched word is always captured; only the valid pulse honours a flush.
            if (state == FETCH && ram_ready) begin
                if_data  <= ram_rdata;
                if_valid <= ~(discard | if_flush);
            end

            if (state == FETCH && (ram_ready || timeoutHit))
                discard <= 1'b0;
            else if (state == FETCH && if_flush)
                discard <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level model, plus directed scenarios.
module tb_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifReq, ifFlush, memRd, memWr, ramReady;
    logic [15:0] ifAddr, memAddr, memWdata, ramRdata;
    logic        ramEn, ramWe, ifValid, memDone, stallIf, stallMem, busErr;
    logic [15:0] ramAddr, ramWdata, ifData, memRdata;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(ifReq), .if_addr(ifAddr), .if_flush(ifFlush),
        .mem_rd(memRd), .mem_wr(memWr), .mem_addr(memAddr), .mem_wdata(memWdata),
        .ram_en(ramEn), .ram_we(ramWe), .ram_addr(ramAddr), .ram_wdata(ramWdata),
        .ram_rdata(ramRdata), .ram_ready(ramReady),
        .if_data(ifData), .if_valid(ifValid),
        .mem_rdata(memRdata), .mem_done(memDone),
        .stall_if(stallIf), .stall_mem(stallMem), .bus_err(busErr)
    );

    always #5 clk = ~clk;

    // Model: who owns the RAM (0 nobody, 1 fetch, 2 data) and what the outputs must show.
    int          who, waited;
    logic [15:0] eAddr, eWdata, eIfData, eMemRdata;
    logic        eWe, eIfValid, eMemDone, eDiscard, eErr;

    task automatic lit(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        who = 0; waited = 0;
        eAddr = '0; eWdata = '0; eIfData = '0; eMemRdata = '0;
        eWe = 0; eIfValid = 0; eMemDone = 0; eDiscard = 0; eErr = 0;
    endtask

    task automatic modelStep();
        logic nIfV, nMD, wantD, wantF, open;
        nIfV  = 0;
        nMD   = 0;
        wantD = (memRd || memWr) && !eMemDone;
        wantF = ifReq && !eIfValid;
        open  = (who == 0) || ramReady;
        if (who == 2 && ramReady) begin
            if (!eWe) eMemRdata = ramRdata;
            nMD   = 1;
            wantD = 0;
        end
        if (who == 1 && ramReady) begin
            eIfData  = ramRdata;
            nIfV     = !(eDiscard || ifFlush);
            eDiscard = 0;
            wantF    = 0;
        end
        if (who != 0 && !ramReady) begin
            if (who == 1 && ifFlush) eDiscard = 1;
            if (waited < 255) waited++;
            if (waited >= TO) begin
                eErr = 1; who = 0; eWe = 0; eDiscard = 0;
            end
        end
        if (open) begin
            if (wantD) begin
                who = 2; eAddr = memAddr; eWe = memWr; eWdata = memWdata; waited = 0;
            end else if (wantF) begin
                who = 1; eAddr = ifAddr; eWe = 0; eWdata = '0; waited = 0;
            end else begin
                who = 0; eWe = 0;
            end
        end
        eIfValid = nIfV;
        eMemDone = nMD;
    endtask

    task automatic compareAll();
        lit("ram_en",    ramEn,    (who != 0));
        lit("ram_we",    ramWe,    eWe);
        lit("ram_addr",  ramAddr,  eAddr);
        lit("ram_wdata", ramWdata, eWdata);
        lit("if_valid",  ifValid,  eIfValid);
        lit("if_data",   ifData,   eIfData);
        lit("mem_done",  memDone,  eMemDone);
        lit("mem_rdata", memRdata, eMemRdata);
        lit("stall_if",  stallIf,  ifReq && !eIfValid);
        lit("stall_mem", stallMem, (memRd || memWr) && !eMemDone);
        lit("bus_err",   busErr,   eErr);
    endtask

    // Called at a falling edge with this cycle's inputs already driven.
    task automatic cycle();
        if (rst) modelReset();
        #1;
        compareAll();
        if (!rst) modelStep();
        @(negedge clk);
    endtask

    initial begin
        logic lastIfV, lastMemD;
        int   n;
        rst = 1; ifReq = 0; ifFlush = 0; memRd = 0; memWr = 0; ramReady = 0;
        ifAddr = '0; memAddr = '0; memWdata = '0; ramRdata = '0;
        modelReset();
        @(negedge clk);
        #1;
        lit("reset ram_en", ramEn, 0);
        lit("reset bus_err", busErr, 0);
        lit("reset ram_addr", ramAddr, 0);
        cycle();
        rst = 0;

        // Single fetch, RAM answers two cycles after ram_en rises.
        ifReq = 1; ifAddr = 16'h0010; cycle();
        #1; lit("f1 ram_en", ramEn, 1); lit("f1 ram_addr", ramAddr, 16'h0010); cycle();
        cycle();
        ramReady = 1; ramRdata = 16'hA5A5; cycle();
        ramReady = 0;
        #1; lit("f1 if_valid", ifValid, 1); lit("f1 if_data", ifData, 16'hA5A5);
        lit("f1 stall_if", stallIf, 0); cycle();
        ifReq = 0; #1; lit("f1 pulse ends", ifValid, 0); cycle();

        // Simultaneous load and fetch: data first, fetch regranted without a bubble.
        ifReq = 1; ifAddr = 16'h0040; memRd = 1; memAddr = 16'h0200; cycle();
        #1; lit("pr ram_addr", ramAddr, 16'h0200); lit("pr stall_if", stallIf, 1);
        ramReady = 1; ramRdata = 16'h5A5A; cycle();
        ramReady = 0;
        #1; lit("pr mem_done", memDone, 1); lit("pr mem_rdata", memRdata, 16'h5A5A);
        lit("pr no bubble", ramEn, 1); lit("pr fetch addr", ramAddr, 16'h0040); cycle();
        memRd = 0; ramReady = 1; ramRdata = 16'h1111; cycle();
        ramReady = 0;
        #1; lit("pr if_valid", ifValid, 1); lit("pr if_data", ifData, 16'h1111); cycle();
        ifReq = 0; cycle();

        // Store: we/wdata held, load register untouched.
        memWr = 1; memAddr = 16'h0300; memWdata = 16'h1234; cycle();
        #1; lit("st ram_we", ramWe, 1); lit("st ram_wdata", ramWdata, 16'h1234); cycle();
        #1; lit("st held we", ramWe, 1); lit("st held addr", ramAddr, 16'h0300);
        ramReady = 1; ramRdata = 16'hFFFF; cycle();
        ramReady = 0;
        #1; lit("st mem_done", memDone, 1); lit("st mem_rdata", memRdata, 16'h5A5A); cycle();
        memWr = 0; cycle();

        // Flush mid-fetch: result dropped, redirected fetch completes normally.
        ifReq = 1; ifAddr = 16'h0080; cycle();
        ifFlush = 1; cycle();
        ifFlush = 0; ifAddr = 16'h0090; ramReady = 1; ramRdata = 16'hBEEF; cycle();
        ramReady = 0;
        #1; lit("fl if_valid", ifValid, 0); lit("fl if_data", ifData, 16'hBEEF); cycle();
        #1; lit("fl refetch addr", ramAddr, 16'h0090);
        ramReady = 1; ramRdata = 16'h0F0F; cycle();
        ramReady = 0;
        #1; lit("fl refetch valid", ifValid, 1); lit("fl refetch data", ifData, 16'h0F0F); cycle();
        ifReq = 0; cycle();

        // Random traffic; RAM always answers before the watchdog expires.
        lastIfV = 0; lastMemD = 0;
        for (int c = 0; c < 3000; c++) begin
            if (lastIfV) ifReq = 0;
            else if (!ifReq && $urandom_range(2) == 0) begin
                ifReq = 1; ifAddr = 16'($urandom);
            end
            if (lastMemD) begin memRd = 0; memWr = 0; end
            else if (!memRd && !memWr && $urandom_range(3) == 0) begin
                if ($urandom_range(1) == 0) memRd = 1; else memWr = 1;
                memAddr = 16'($urandom); memWdata = 16'($urandom);
            end
            ifFlush  = ($urandom_range(9) == 0);
            ramRdata = 16'($urandom);
            if (who != 0) ramReady = (waited >= TO - 1) || ($urandom_range(1) == 0);
            else          ramReady = ($urandom_range(7) == 0);
            lastIfV  = eIfValid;
            lastMemD = eMemDone;
            cycle();
        end
        ifReq = 0; memRd = 0; memWr = 0; ifFlush = 0; ramReady = 0;
        cycle(); cycle();
        while (who != 0) begin ramReady = 1; cycle(); ramReady = 0; end
        cycle();

        // Reset in the middle of a load.
        memRd = 1; memAddr = 16'h0400; cycle();
        #1; lit("rs busy", ramEn, 1);
        rst = 1; #1;
        lit("rs ram_en", ramEn, 0); lit("rs ram_addr", ramAddr, 0);
        lit("rs mem_rdata", memRdata, 0); lit("rs if_data", ifData, 0);
        cycle();
        memRd = 0; rst = 0;
        for (int i = 0; i < 5; i++) begin
            ramReady = (i == 1);
            #1; lit("rs no done", memDone, 0);
            cycle();
        end
        ramReady = 0;

        // RAM never answers: watchdog aborts after TO busy cycles.
        ifReq = 1; ifAddr = 16'h0055; cycle();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (busErr) break;
            if (ramEn) n++;
            cycle();
        end
        lit("to busy cycles", 16'(n), 16'(TO));
        lit("to bus_err", busErr, 1);
        lit("to ram_en", ramEn, 0);
        lit("to no valid", ifValid, 0);
        cycle();
        ifReq = 0;
        repeat (4) cycle();
        #1; lit("to sticky", busErr, 1);
        rst = 1; cycle();
        #1; lit("to cleared", busErr, 0);
        rst = 0; cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
